// File: rtl/pc_next_unit.sv
// Program-counter generator: owns the fetch and decode PCs, steps sequentially,
// applies taken branch/jump targets and traps on misaligned targets.
module pc_next_unit #(
  parameter int PC_W     = 10,
  parameter int INC      = 4,
  parameter int RESET_PC = 0,
  parameter int TRAP_PC  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_vld,
  input  logic [1:0]      redirect_mode,
  input  logic            branch_taken,
  input  logic [31:0]     imm,
  input  logic [31:0]     rs1,
  input  logic            trap_ack,
  output logic [PC_W-1:0] pc_f,
  output logic [PC_W-1:0] pc_d,
  output logic            d_valid,
  output logic [31:0]     pc_imm,
  output logic [31:0]     link,
  output logic            misalign
);

  typedef enum logic {
    RUN,
    HALT_MIS
  } state_t;

  localparam logic [PC_W-1:0] INC_PC   = PC_W'(INC);
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] TRAP_PC_V  = PC_W'(TRAP_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_f_q, pc_f_d;
  logic [PC_W-1:0] pc_d_q, pc_d_d;
  logic            d_valid_q, d_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     target;
  logic            take;

  // jalr clears bit 0 of rs1+imm; every other mode (reserved 11 included) is pc_d-relative
  always_comb begin
    target = 32'(pc_d_q) + imm;
    if (redirect_mode == 2'b10) begin
      target = (rs1 + imm) & ~32'h1;
    end
  end

  always_comb begin
    take = 1'b0;
    if (redirect_vld && d_valid_q && (state_q == RUN)) begin
      case (redirect_mode)
        2'b00:   take = branch_taken;
        2'b01:   take = 1'b1;
        2'b10:   take = 1'b1;
        default: take = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pc_d_d     = pc_d_q;
    d_valid_d  = d_valid_q;
    misalign_d = misalign_q;
    if (state_q == RUN) begin
      // a take beats stall so the wrong-path fetch is always flushed
      if (take && (target[1:0] != 2'b00)) begin
        d_valid_d  = 1'b0;
        misalign_d = 1'b1;
        state_d    = HALT_MIS;
      end else if (take) begin
        pc_f_d    = target[PC_W-1:0];
        d_valid_d = 1'b0;
      end else if (!stall) begin
        pc_d_d    = pc_f_q;
        d_valid_d = 1'b1;
        pc_f_d    = pc_f_q + INC_PC;
      end
    end else begin
      d_valid_d  = 1'b0;
      misalign_d = 1'b1;
      if (trap_ack) begin
        pc_f_d     = TRAP_PC_V;
        misalign_d = 1'b0;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_f_q     <= RESET_PC_V;
      pc_d_q     <= '0;
      d_valid_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pc_d_q     <= pc_d_d;
      d_valid_q  <= d_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_f     = pc_f_q;
  assign pc_d     = pc_d_q;
  assign d_valid  = d_valid_q;
  assign misalign = misalign_q;
  assign pc_imm   = target;
  assign link     = 32'(pc_d_q) + 32'(INC);

endmodule
